// File: rtl/vga_display_core.sv
// VGA display core: free-running raster timing generator that issues pixel
// requests, built-in test patterns (colour bars, white, scrolling checker),
// and a latency-matched pipeline that realigns sync/blanking with the pixel
// data returned by a fixed-latency source.
module vga_display_core #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int HSYNC_POL     = 0,
  parameter int VSYNC_POL     = 0,
  parameter int COLOR_W       = 4,
  parameter int PIXEL_LATENCY = 1,
  parameter int CHECK_LOG2    = 4
) (
  input  logic               clk_25_175,
  input  logic               rst,
  input  logic [1:0]         mode,
  output logic [9:0]         req_x,
  output logic [9:0]         req_y,
  output logic               req_valid,
  output logic [31:0]        frame,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic               hsync,
  output logic               vsync,
  output logic               visible,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic HS_ACT = (HSYNC_POL != 0);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  localparam logic [COLOR_W-1:0] CMAX = {COLOR_W{1'b1}};

  // Packed pipeline word: {hsync active, vsync active, valid, use source, r, g, b}
  localparam int PW = 4 + 3 * COLOR_W;

  // Bar index 0..7 from elaboration-time boundaries i*H_VISIBLE/8.
  function automatic logic [2:0] bar_index(input logic [9:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(i * H_VISIBLE / 8)) idx = 3'(i);
    end
    return idx;
  endfunction

  // Test-pattern colour {r, g, b} for the latched mode.
  function automatic logic [3*COLOR_W-1:0] pattern_rgb(input logic [1:0] m,
                                                        input logic [2:0] bar,
                                                        input logic       chk);
    logic [3*COLOR_W-1:0] c;
    c = '0;
    case (m)
      2'd1: c = {bar[0] ? CMAX : '0, bar[1] ? CMAX : '0, bar[2] ? CMAX : '0};
      2'd2: c = {3{CMAX}};
      2'd3: c = chk ? {3{CMAX}} : '0;
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [1:0] mode_q;

  // Raster counters and completed-frame count.
  always_ff @(posedge clk_25_175) begin
    if (rst) begin
      req_x <= 10'd0;
      req_y <= 10'd0;
      frame <= 32'd0;
    end else if (req_x == H_LAST) begin
      req_x <= 10'd0;
      if (req_y == V_LAST) begin
        req_y <= 10'd0;
        frame <= frame + 32'd1;
      end else begin
        req_y <= req_y + 10'd1;
      end
    end else begin
      req_x <= req_x + 10'd1;
    end
  end

  // Mode only changes on the last request of a frame so a frame never tears.
  always_ff @(posedge clk_25_175) begin
    if (rst) begin
      mode_q <= 2'd0;
    end else if (req_x == H_LAST && req_y == V_LAST) begin
      mode_q <= mode;
    end
  end

  assign req_valid = (req_x < H_VIS) && (req_y < V_VIS);

  // ---- stage p0: request-time sync, valid and pattern ----
  logic                 hs_p0, vs_p0, vld_p0, src_p0, chk_p0;
  logic [3*COLOR_W-1:0] pat_p0;
  logic [PW-1:0]        pk_p0;

  assign hs_p0  = (req_x >= HS_BEG) && (req_x < HS_END);
  assign vs_p0  = (req_y >= VS_BEG) && (req_y < VS_END);
  assign vld_p0 = req_valid;
  assign src_p0 = (mode_q == 2'd0);
  // x+frame wraps in 10 bits so the checker scrolls one pixel per frame.
  assign chk_p0 = |((((req_x + frame[9:0]) >> CHECK_LOG2) ^ (req_y >> CHECK_LOG2)) & 10'd1);
  assign pat_p0 = pattern_rgb(mode_q, bar_index(req_x), chk_p0);
  assign pk_p0  = {hs_p0, vs_p0, vld_p0, src_p0, pat_p0};

  // ---- stage p1: PIXEL_LATENCY-deep delay line, aligned with source data ----
  logic [PW-1:0] pk_p1;

  if (PIXEL_LATENCY == 0) begin : g_no_dly
    assign pk_p1 = pk_p0;
  end else begin : g_dly
    logic [PW-1:0] dly [PIXEL_LATENCY];

    // Shift register; cleared on reset so no stale sync pulses or pixels emerge.
    always_ff @(posedge clk_25_175) begin
      if (rst) begin
        for (int i = 0; i < PIXEL_LATENCY; i++) dly[i] <= '0;
      end else begin
        dly[0] <= pk_p0;
        for (int i = 1; i < PIXEL_LATENCY; i++) dly[i] <= dly[i-1];
      end
    end

    assign pk_p1 = dly[PIXEL_LATENCY-1];
  end

  logic               hs_p1, vs_p1, vld_p1, src_p1;
  logic [COLOR_W-1:0] pat_r_p1, pat_g_p1, pat_b_p1;
  logic [COLOR_W-1:0] sel_r_p1, sel_g_p1, sel_b_p1;

  assign {hs_p1, vs_p1, vld_p1, src_p1, pat_r_p1, pat_g_p1, pat_b_p1} = pk_p1;

  assign sel_r_p1 = src_p1 ? pix_r : pat_r_p1;
  assign sel_g_p1 = src_p1 ? pix_g : pat_g_p1;
  assign sel_b_p1 = src_p1 ? pix_b : pat_b_p1;

  // ---- stage p2: output registers driving the pins ----
  // Registers polarity-corrected syncs and blanked colour together.
  always_ff @(posedge clk_25_175) begin
    if (rst) begin
      hsync   <= ~HS_ACT;
      vsync   <= ~VS_ACT;
      visible <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      hsync   <= hs_p1 ? HS_ACT : ~HS_ACT;
      vsync   <= vs_p1 ? VS_ACT : ~VS_ACT;
      visible <= vld_p1;
      r       <= vld_p1 ? sel_r_p1 : '0;
      g       <= vld_p1 ? sel_g_p1 : '0;
      b       <= vld_p1 ? sel_b_p1 : '0;
    end
  end

endmodule

// File: tb/tb_vga_display_core.sv
// Bench for vga_display_core: small raster, PIXEL_LATENCY=3, randomized mode
// changes and resets, checked every cycle against a raster-index model.
module tb_vga_display_core;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 40, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int L  = 3;
  localparam int CW = 4;
  localparam int CL = 2;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;

  logic          clk;
  logic          rst;
  logic [1:0]    mode;
  logic [9:0]    req_x, req_y;
  logic          req_valid;
  logic [31:0]   frame;
  logic [CW-1:0] pix_r, pix_g, pix_b;
  logic          hsync, vsync, visible;
  logic [CW-1:0] r, g, b;

  vga_display_core #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(0), .VSYNC_POL(1), .COLOR_W(CW),
    .PIXEL_LATENCY(L), .CHECK_LOG2(CL)
  ) dut (
    .clk_25_175(clk), .rst(rst), .mode(mode),
    .req_x(req_x), .req_y(req_y), .req_valid(req_valid), .frame(frame),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hsync(hsync), .vsync(vsync), .visible(visible),
    .r(r), .g(g), .b(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: k = requests issued since the last reset edge.
  int k = 0;
  int fmode [0:63];
  logic [9:0] hx [0:L];
  logic [9:0] hy [0:L];

  // Source image: r = x[3:0], g = y[3:0], b = x^y.
  function automatic logic [11:0] src(input logic [9:0] x, input logic [9:0] y);
    return {x[3:0], y[3:0], x[3:0] ^ y[3:0]};
  endfunction

  // Expected {hsync, vsync, visible, r, g, b} produced by request number n.
  function automatic logic [14:0] exp_pins(input int n);
    int x, y, f, m, i;
    logic hs, vs, vis;
    logic [11:0] rgb;
    if (n < 0) return {~HPOL, ~VPOL, 1'b0, 12'h000};
    x = n % HT;
    y = (n / HT) % VT;
    f = n / FT;
    m = fmode[f];
    hs  = (x >= HV + HF && x < HV + HF + HS) ? HPOL : ~HPOL;
    vs  = (y >= VV + VF && y < VV + VF + VS) ? VPOL : ~VPOL;
    vis = (x < HV) && (y < VV);
    rgb = 12'h000;
    if (vis) begin
      case (m)
        0: rgb = src(10'(x), 10'(y));
        1: begin
          i = x * 8 / HV;
          rgb = {(i & 1) != 0 ? 4'hf : 4'h0,
                 (i & 2) != 0 ? 4'hf : 4'h0,
                 (i & 4) != 0 ? 4'hf : 4'h0};
        end
        2: rgb = 12'hfff;
        default: rgb = (((((x + f) % 1024) >> CL) ^ (y >> CL)) % 2) != 0 ? 12'hfff : 12'h000;
      endcase
    end
    return {hs, vs, vis, rgb};
  endfunction

  // One clock: advance the model, compare everything, then act as the source.
  task automatic step();
    logic [11:0] p;
    @(posedge clk);
    if (rst) begin
      k = 0;
      fmode[0] = 0;
    end else begin
      k++;
      if (k % FT == 0 && k / FT < 64) fmode[k / FT] = int'(mode);
    end
    #1;
    check("req", {frame, req_y, req_x, req_valid},
          {32'(k / FT), 10'((k / HT) % VT), 10'(k % HT),
           1'((k % HT) < HV && ((k / HT) % VT) < VV)});
    check("pins", {hsync, vsync, visible, r, g, b}, exp_pins(k - L - 1));
    for (int i = L; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
    end
    hx[0] = req_x;
    hy[0] = req_y;
    p = src(hx[L], hy[L]);
    {pix_r, pix_g, pix_b} = p;
  endtask

  // Step until the request is (x, y) in frame f, bounded.
  task automatic run_to(input int x, input int y, input int f);
    int c;
    c = 0;
    while (!(req_x == 10'(x) && req_y == 10'(y) && frame == 32'(f)) && c < 3 * FT) begin
      step();
      c++;
    end
    if (c >= 3 * FT) check("timeout", 64'(c), 64'd0);
  endtask

  int c, w;

  initial begin
    rst  = 1'b1;
    mode = 2'd0;
    {pix_r, pix_g, pix_b} = 12'h000;
    for (int i = 0; i <= L; i++) begin
      hx[i] = 10'd0;
      hy[i] = 10'd0;
    end
    for (int i = 0; i < 64; i++) fmode[i] = 0;

    repeat (3) step();
    check("rst_pins", {hsync, vsync, visible, r, g, b}, {1'b1, 1'b0, 1'b0, 12'h000});
    check("rst_cnt", {frame, req_y, req_x}, 64'd0);
    rst = 1'b0;

    // visible follows req_valid (high at 0,0) by L+1 cycles
    c = 0;
    while (!visible && c < 100) begin
      step();
      c++;
    end
    check("vis_delay", 64'(c), 64'(L + 1));

    // hsync starts L+1 cycles after req_x enters the sync window, lasts H_SYNC
    run_to(HV + HF, 0, 0);
    c = 0;
    while (hsync != HPOL && c < 50) begin
      step();
      c++;
    end
    check("hs_delay", 64'(c), 64'(L + 1));
    w = 0;
    while (hsync == HPOL && w < 2 * HT) begin
      step();
      w++;
    end
    check("hs_width", 64'(w), 64'(HS));

    // source column x=5 on line 3 shows r=5
    run_to(5 + L + 1, 3, 0);
    check("src_x5", 64'(r), 64'd5);

    // switch to white mid-frame: rest of frame 0 stays source
    run_to(0, 10, 0);
    mode = 2'd2;
    run_to(7 + L + 1, 12, 0);
    check("still_src", {r, g, b}, {4'd7, 4'd12, 4'd7 ^ 4'd12});
    run_to(10 + L + 1, 2, 1);
    check("white", {r, g, b}, 64'hfff);

    // colour bars in frame 2
    mode = 2'd1;
    run_to(0 + L + 1, 1, 2);
    check("bar_x0", {r, g, b}, 64'h000);
    run_to(HV / 8 + L + 1, 1, 2);
    check("bar_x8", {r, g, b}, 64'hf00);
    run_to(HV - 1 + L + 1, 1, 2);
    check("bar_xlast", {r, g, b}, 64'hfff);

    // reset mid-line, then check timing restarts at 0,0
    mode = 2'd3;
    run_to(30, 20, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_pins", {hsync, vsync, visible, r, g, b}, {1'b1, 1'b0, 1'b0, 12'h000});
    check("rst_mid_cnt", {frame, req_y, req_x}, 64'd0);
    step();
    check("rst_mid_x1", 64'(req_x), 64'd1);

    // randomized run: checker frames, random mode changes and resets
    for (int n = 0; n < 5 * FT; n++) begin
      if ($urandom_range(0, 2999) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7999) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
